ulpi_reg_ctrl: RTL and testbench

ULPI_REG_CTRL -- requirements
Module: ulpi_reg_ctrl

---
 rtl/ulpi_pkg.sv | 23 ++
 rtl/ulpi_rr_arb.sv | 34 +++
 rtl/ulpi_reg_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ulpi_reg_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI register-access controller: FSM states,
// TXCMD prefixes and the NOOP bus value.
package ulpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TXCMD,
    ST_WDATA,
    ST_STP,
    ST_RD_TURN,
    ST_RD_DATA,
    ST_ABORT
  } state_e;

  localparam logic [1:0] TXCMD_REGW = 2'b10;
  localparam logic [1:0] TXCMD_REGR = 2'b11;
  localparam logic [7:0] ULPI_NOOP  = 8'h00;

  function automatic logic [7:0] regCmd(input logic isWrite, input logic [5:0] addr);
    return {(isWrite ? TXCMD_REGW : TXCMD_REGR), addr};
  endfunction

endpackage

// File: rtl/ulpi_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the preferred requester and
// moves past the served one only when a transaction completes.
module ulpi_rr_arb
  import ulpi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       served_i,
  output logic       valid_o,
  output logic       grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    valid_o = |req_i;
    grant_o = req_i[ptr_q] ? ptr_q : ~ptr_q;
    ptr_d   = ptr_q;
    if (advance_i) begin
      ptr_d = ~served_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register read/write controller for two requesters, with
// RX-preemption retry and a no-progress watchdog.
module ulpi_reg_ctrl
  import ulpi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_stp,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [5:0] addr0,
  input  logic [5:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] done,
  output logic       err,
  output logic [7:0] rdata
);

  localparam int WdW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic             dir_q;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             grant_q, grant_d;
  logic             cmdWe_q, cmdWe_d;
  logic [5:0]       cmdAddr_q, cmdAddr_d;
  logic [7:0]       cmdWdata_q, cmdWdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [1:0]       done_q, done_d;
  logic             err_q, err_d;
  logic             arbValid, arbGrant, advance, finish, timedOut;

  ulpi_rr_arb uArb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .advance_i (advance),
    .served_i  (grant_q),
    .valid_o   (arbValid),
    .grant_o   (arbGrant)
  );

  // A new grant waits out the done cycle so the just-served requester can drop req.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cmdWe_d    = cmdWe_q;
    cmdAddr_d  = cmdAddr_q;
    cmdWdata_d = cmdWdata_q;
    rdata_d    = rdata_q;
    done_d     = 2'b00;
    err_d      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    timedOut   = (wd_q == WdW'(TIMEOUT - 1));

    case (state_q)
      ST_IDLE: begin
        if (arbValid && !ulpi_dir && !dir_q && (done_q == 2'b00)) begin
          state_d    = ST_TXCMD;
          grant_d    = arbGrant;
          cmdWe_d    = we[arbGrant];
          cmdAddr_d  = arbGrant ? addr1 : addr0;
          cmdWdata_d = arbGrant ? wdata1 : wdata0;
        end
      end
      ST_TXCMD: begin
        if (ulpi_dir) begin
          state_d = ST_ABORT;
        end else if (ulpi_nxt) begin
          state_d = cmdWe_q ? ST_WDATA : ST_RD_TURN;
        end else if (timedOut) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end
      end
      ST_WDATA: begin
        if (ulpi_dir) begin
          state_d = ST_ABORT;
        end else if (ulpi_nxt) begin
          state_d = ST_STP;
        end else if (timedOut) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end
      end
      ST_STP: begin
        finish = 1'b1;
      end
      ST_RD_TURN: begin
        if (ulpi_dir && ulpi_nxt) begin
          state_d = ST_ABORT;
        end else if (ulpi_dir) begin
          state_d = ST_RD_DATA;
        end else if (timedOut) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end
      end
      ST_RD_DATA: begin
        rdata_d = ulpi_data_in;
        finish  = 1'b1;
      end
      ST_ABORT: begin
        if (!ulpi_dir && !dir_q) begin
          state_d = ST_TXCMD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_d = ST_IDLE;
      done_d  = grant_q ? 2'b10 : 2'b01;
      advance = 1'b1;
    end

    // PHY-owned bus time in ABORT must not count towards the watchdog.
    if ((state_d != state_q) || ((state_q == ST_ABORT) && ulpi_dir)) begin
      wd_d = '0;
    end else if (wd_q != WdW'(TIMEOUT)) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      wd_q       <= '0;
      grant_q    <= 1'b0;
      cmdWe_q    <= 1'b0;
      cmdAddr_q  <= 6'h00;
      cmdWdata_q <= 8'h00;
      rdata_q    <= 8'h00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= ulpi_dir;
      wd_q       <= wd_d;
      grant_q    <= grant_d;
      cmdWe_q    <= cmdWe_d;
      cmdAddr_q  <= cmdAddr_d;
      cmdWdata_q <= cmdWdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    ulpi_data_oe = !ulpi_dir && !dir_q;
    ulpi_stp     = (state_q == ST_STP);
    case (state_q)
      ST_TXCMD: ulpi_data_out = regCmd(cmdWe_q, cmdAddr_q);
      ST_WDATA: ulpi_data_out = cmdWdata_q;
      default:  ulpi_data_out = ULPI_NOOP;
    endcase
  end

  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Scoreboard bench for ulpi_reg_ctrl: a scripted PHY drives the bus, expected
// completions are queued at issue and matched by an independent done monitor.
module tb_ulpi_reg_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       ulpi_dir, ulpi_nxt;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe, ulpi_stp;
  logic [1:0] req, we;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] done;
  logic       err;
  logic [7:0] rdata;

  typedef struct {
    int         idx;
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t       expQ[$];
  int         tests = 0;
  int         fails = 0;
  int         pref;
  logic [7:0] lastRd;
  logic       curWe[2];
  logic [5:0] curAddr[2];
  logic [7:0] curWd[2];

  always #5 clk = ~clk;

  ulpi_reg_ctrl #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .ulpi_dir      (ulpi_dir),
    .ulpi_nxt      (ulpi_nxt),
    .ulpi_data_in  (ulpi_data_in),
    .ulpi_data_out (ulpi_data_out),
    .ulpi_data_oe  (ulpi_data_oe),
    .ulpi_stp      (ulpi_stp),
    .req           (req),
    .we            (we),
    .addr0         (addr0),
    .addr1         (addr1),
    .wdata0        (wdata0),
    .wdata1        (wdata1),
    .done          (done),
    .err           (err),
    .rdata         (rdata)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done !== 2'b00) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpectedDone: got done=%b, expected no completion", done);
      end else begin
        e = expQ.pop_front();
        checkOutput("doneWho", {30'd0, done}, (e.idx == 1) ? 32'd2 : 32'd1);
        checkOutput("errFlag", {31'd0, err}, {31'd0, e.err});
        checkOutput("rdata", {24'd0, rdata}, {24'd0, e.rdata});
      end
    end
  end

  task automatic applyStimulus(input int i, input logic w, input logic [5:0] a, input logic [7:0] d);
    curWe[i]   = w;
    curAddr[i] = a;
    curWd[i]   = d;
    we[i]      = w;
    if (i == 0) begin
      addr0  = a;
      wdata0 = d;
    end else begin
      addr1  = a;
      wdata1 = d;
    end
    req[i] = 1'b1;
  endtask

  task automatic phyCmd(input logic [7:0] cmd, input int waitCycles);
    int n = 0;
    while (ulpi_data_out == 8'h00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("txcmdByte", {24'd0, ulpi_data_out}, {24'd0, cmd});
    checkOutput("txcmdOe", {31'd0, ulpi_data_oe}, 32'd1);
    repeat (waitCycles) begin
      @(negedge clk);
      checkOutput("txcmdHold", {24'd0, ulpi_data_out}, {24'd0, cmd});
    end
    ulpi_nxt = 1'b1;
    @(negedge clk);
    ulpi_nxt = 1'b0;
  endtask

  task automatic phyWdata(input logic [7:0] d, input int waitCycles);
    checkOutput("wdataByte", {24'd0, ulpi_data_out}, {24'd0, d});
    repeat (waitCycles) begin
      @(negedge clk);
      checkOutput("wdataHold", {24'd0, ulpi_data_out}, {24'd0, d});
    end
    ulpi_nxt = 1'b1;
    @(negedge clk);
    ulpi_nxt = 1'b0;
    checkOutput("stpHigh", {31'd0, ulpi_stp}, 32'd1);
    checkOutput("stpData", {24'd0, ulpi_data_out}, 32'd0);
    @(negedge clk);
    checkOutput("stpLow", {31'd0, ulpi_stp}, 32'd0);
  endtask

  task automatic phyRead(input logic [7:0] d, input int turnWait);
    repeat (turnWait) @(negedge clk);
    ulpi_dir = 1'b1;
    @(negedge clk);
    checkOutput("rdOeOff", {31'd0, ulpi_data_oe}, 32'd0);
    ulpi_data_in = d;
    @(negedge clk);
    ulpi_dir     = 1'b0;
    ulpi_data_in = 8'h00;
  endtask

  task automatic phyAbort(input int len, input logic nxtVal);
    ulpi_dir = 1'b1;
    ulpi_nxt = nxtVal;
    repeat (len) begin
      @(negedge clk);
      ulpi_nxt = 1'b0;
      checkOutput("abortNoDone", {30'd0, done}, 32'd0);
      checkOutput("abortOeOff", {31'd0, ulpi_data_oe}, 32'd0);
    end
    ulpi_dir = 1'b0;
    @(negedge clk);
    checkOutput("abortTurnNoop", {24'd0, ulpi_data_out}, 32'd0);
  endtask

  task automatic waitDone(input int i);
    int n = 0;
    while (done[i] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("doneSeen", {31'd0, done[i]}, 32'd1);
    req[i] = 1'b0;
  endtask

  task automatic serve(input int i, input int cmdWait, input int dataWait, input bit doAbort,
                       input int abortLen, input int turnWait, input logic [7:0] rdVal);
    exp_t       e;
    logic [7:0] cmd;
    cmd     = (curWe[i] ? 8'h80 : 8'hC0) + {2'b00, curAddr[i]};
    e.idx   = i;
    e.err   = 1'b0;
    e.rdata = curWe[i] ? lastRd : rdVal;
    lastRd  = e.rdata;
    expQ.push_back(e);
    phyCmd(cmd, cmdWait);
    if (doAbort) begin
      phyAbort(abortLen, !curWe[i]);
      phyCmd(cmd, cmdWait);
    end
    if (curWe[i]) phyWdata(curWd[i], dataWait);
    else          phyRead(rdVal, turnWait);
    waitDone(i);
    pref = 1 - i;
  endtask

  task automatic serveRand(input int i);
    serve(i, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
          $urandom_range(1, 4), $urandom_range(0, 2), 8'($urandom));
  endtask

  task automatic randReq(input int i);
    applyStimulus(i, 1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: got no end of run, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t       e;
    int         sel, cnt, mask, n;
    logic       stpSeen;
    logic [5:0] a;

    reset = 1'b1; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
    req = 2'b00; we = 2'b00; addr0 = 6'h00; addr1 = 6'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    pref = 0; lastRd = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstStp", {31'd0, ulpi_stp}, 32'd0);
    checkOutput("rstData", {24'd0, ulpi_data_out}, 32'd0);
    checkOutput("rstDone", {30'd0, done}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    checkOutput("rstRdata", {24'd0, rdata}, 32'd0);
    checkOutput("rstOe", {31'd0, ulpi_data_oe}, 32'd1);

    // Both requesters held: requester 0 first after reset, then strict alternation.
    applyStimulus(0, 1'b1, 6'h04, 8'h11);
    applyStimulus(1, 1'b1, 6'h05, 8'h22);
    for (int k = 0; k < 4; k++) begin
      sel = pref;
      serve(sel, 0, 1, 1'b0, 1, 0, 8'h00);
      if (k < 2) begin
        a    = 6'($urandom);
        a[0] = sel[0];
        applyStimulus(sel, 1'b1, a, 8'($urandom));
      end
    end

    applyStimulus(0, 1'b1, 6'h0A, 8'h55);
    serve(0, 1, 0, 1'b0, 1, 0, 8'h00);

    applyStimulus(1, 1'b0, 6'h16, 8'h00);
    serve(1, 0, 0, 1'b0, 1, 0, 8'h3C);

    applyStimulus(0, 1'b1, 6'h0A, 8'h55);
    serve(0, 0, 0, 1'b1, 4, 0, 8'h00);

    // PHY never acknowledges the TXCMD.
    applyStimulus(0, 1'b1, 6'h21, 8'hA5);
    e.idx = 0; e.err = 1'b1; e.rdata = lastRd;
    expQ.push_back(e);
    n = 0;
    while (ulpi_data_out == 8'h00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("toCmd", {24'd0, ulpi_data_out}, 32'hA1);
    cnt = 0;
    stpSeen = 1'b0;
    while (done[0] !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (ulpi_stp) stpSeen = 1'b1;
    end
    checkOutput("timeoutCycles", cnt, TO);
    checkOutput("timeoutNoStp", {31'd0, stpSeen}, 32'd0);
    waitDone(0);
    pref = 1;
    @(negedge clk);
    checkOutput("idleAfterTimeout", {24'd0, ulpi_data_out}, 32'd0);

    for (int k = 0; k < 20; k++) begin
      mask = $urandom_range(1, 3);
      if (mask[0]) randReq(0);
      if (mask[1]) randReq(1);
      if (mask == 3) begin
        sel = pref;
        serveRand(sel);
        serveRand(1 - sel);
      end else begin
        serveRand((mask == 1) ? 0 : 1);
      end
    end

    // Reset in the middle of a write: abandoned silently, pointer back to requester 0.
    applyStimulus(0, 1'b1, 6'h0A, 8'h55);
    phyCmd(8'h8A, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req   = 2'b00;
    checkOutput("midRstStp", {31'd0, ulpi_stp}, 32'd0);
    checkOutput("midRstData", {24'd0, ulpi_data_out}, 32'd0);
    checkOutput("midRstDone", {30'd0, done}, 32'd0);
    checkOutput("midRstErr", {31'd0, err}, 32'd0);
    checkOutput("midRstRdata", {24'd0, rdata}, 32'd0);
    lastRd = 8'h00;
    pref   = 0;
    @(negedge clk);
    checkOutput("stpAfterReset", {31'd0, ulpi_stp}, 32'd0);
    checkOutput("noDoneAfterReset", {30'd0, done}, 32'd0);
    randReq(0);
    randReq(1);
    serveRand(0);
    serveRand(1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
